// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART receive path
package uart_pkg;

    localparam int   DATA_BITS = 8;
    localparam int   CSUM_W    = 32;
    localparam logic LINE_IDLE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo_buf.sv
// rtl/uart_rx_fifo_buf.sv - circular byte FIFO with push/pop, head data and occupancy
module uart_rx_fifo_buf
    import uart_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = DATA_BITS
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic                    i_push,
    input  logic [WIDTH-1:0]        i_push_data,
    input  logic                    i_pop,
    output logic [WIDTH-1:0]        o_head,
    output logic [$clog2(DEPTH):0]  o_count,
    output logic                    o_full,
    output logic                    o_empty,
    output logic                    o_push_drop
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_pop;
    logic w_do_push;

    // A pop frees the slot in the same cycle, so a full FIFO can still accept a push then
    always_comb begin
        o_empty     = (r_count == '0);
        o_full      = (r_count == CNT_W'(DEPTH));
        w_do_pop    = i_pop & ~o_empty;
        w_do_push   = i_push & (~o_full | w_do_pop);
        o_push_drop = i_push & ~w_do_push;
        o_count     = r_count;
        o_head      = o_empty ? '0 : r_mem[r_rd_ptr];
    end

    // Storage array; contents are don't-care until written, the head is masked while empty
    always_ff @(posedge clock) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 8N1 UART receiver with output FIFO, checksum and sticky flags (option: UART_RX_FIFO_SYNC_EN)
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int cycles_per_bit = 3,
    parameter int fifo_depth     = 4
) (
    input  logic                          clock,
    input  logic                          tock_reset_n,
    input  logic                          tock_serial,
    input  logic                          tock_pop,
    output logic                          get_valid_ret,
    output logic [DATA_BITS-1:0]          get_data_ret,
    output logic [$clog2(fifo_depth):0]   get_count_ret,
    output logic [CSUM_W-1:0]             get_checksum_ret,
    output logic                          get_frame_err_ret,
    output logic                          get_overflow_ret,
    output logic                          get_busy_ret
);

    localparam int CNT_W = $clog2(cycles_per_bit) + 1;
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(cycles_per_bit / 2);
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(cycles_per_bit - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

    rx_state_t              r_state;
    rx_state_t              w_next_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [BIT_W-1:0]       r_bit_idx;
    logic [DATA_BITS-1:0]   r_shift;
    logic [CSUM_W-1:0]      r_csum;
    logic                   r_frame_err;
    logic                   r_overflow;
    logic                   r_wait_high;
    logic                   w_rx;

    logic w_start_det;
    logic w_start_ok;
    logic w_data_sample;
    logic w_stop_good;
    logic w_stop_bad;
    logic w_fifo_empty;
    logic w_fifo_full;
    logic w_fifo_drop;

`ifdef UART_RX_FIFO_SYNC_EN
    logic [1:0] r_sync;

    // Two-flop synchronizer for the asynchronous line, parked at the idle level in reset
    always_ff @(posedge clock) begin
        if (!tock_reset_n) begin
            r_sync <= {2{LINE_IDLE}};
        end else begin
            r_sync <= {r_sync[0], tock_serial};
        end
    end

    assign w_rx = r_sync[1];
`else
    assign w_rx = tock_serial;
`endif

    // FSM state register
    always_ff @(posedge clock) begin
        if (!tock_reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state: a start must still be low at half-bit, then 8 data bits, then stop
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!w_rx && !r_wait_high) begin
                    w_next_state = ST_START;
                end
            end
            ST_START: begin
                if (r_cnt == HALF_CNT) begin
                    w_next_state = w_rx ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (r_cnt == BIT_END && r_bit_idx == LAST_BIT) begin
                    w_next_state = ST_STOP;
                end
            end
            ST_STOP: begin
                if (r_cnt == BIT_END) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // FSM outputs: single-cycle strobes that drive the sampling datapath
    always_comb begin
        w_start_det   = 1'b0;
        w_start_ok    = 1'b0;
        w_data_sample = 1'b0;
        w_stop_good   = 1'b0;
        w_stop_bad    = 1'b0;
        get_busy_ret  = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE:  w_start_det   = !w_rx && !r_wait_high;
            ST_START: w_start_ok    = (r_cnt == HALF_CNT) && !w_rx;
            ST_DATA:  w_data_sample = (r_cnt == BIT_END);
            ST_STOP: begin
                w_stop_good = (r_cnt == BIT_END) && w_rx;
                w_stop_bad  = (r_cnt == BIT_END) && !w_rx;
            end
            default: ;
        endcase
    end

    // Bit timing counter; the start edge already consumed one clock, hence the load of 1
    always_ff @(posedge clock) begin
        if (!tock_reset_n) begin
            r_cnt <= '0;
        end else if (w_start_det) begin
            r_cnt <= CNT_W'(1);
        end else if (w_start_ok) begin
            r_cnt <= '0;
        end else if (r_state == ST_START) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else if (r_state == ST_DATA || r_state == ST_STOP) begin
            r_cnt <= (r_cnt == BIT_END) ? '0 : r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= '0;
        end
    end

    // LSB-first shift register and data bit index
    always_ff @(posedge clock) begin
        if (!tock_reset_n) begin
            r_shift   <= '0;
            r_bit_idx <= '0;
        end else if (w_start_ok) begin
            r_bit_idx <= '0;
        end else if (w_data_sample) begin
            r_shift   <= {w_rx, r_shift[DATA_BITS-1:1]};
            r_bit_idx <= r_bit_idx + BIT_W'(1);
        end
    end

    // Checksum of good frames, sticky flags, and the wait-for-idle guard after a bad stop
    always_ff @(posedge clock) begin
        if (!tock_reset_n) begin
            r_csum      <= '0;
            r_frame_err <= 1'b0;
            r_overflow  <= 1'b0;
            r_wait_high <= 1'b0;
        end else begin
            if (w_stop_good) begin
                r_csum <= r_csum + CSUM_W'(r_shift);
            end
            if (w_stop_bad) begin
                r_frame_err <= 1'b1;
                r_wait_high <= 1'b1;
            end else if (r_state == ST_IDLE && w_rx) begin
                r_wait_high <= 1'b0;
            end
            if (w_fifo_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    uart_rx_fifo_buf #(
        .DEPTH (fifo_depth),
        .WIDTH (DATA_BITS)
    ) u_buf (
        .clock       (clock),
        .resetn      (tock_reset_n),
        .i_push      (w_stop_good),
        .i_push_data (r_shift),
        .i_pop       (tock_pop),
        .o_head      (get_data_ret),
        .o_count     (get_count_ret),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_push_drop (w_fifo_drop)
    );

    assign get_valid_ret     = ~w_fifo_empty;
    assign get_checksum_ret  = r_csum;
    assign get_frame_err_ret = r_frame_err;
    assign get_overflow_ret  = r_overflow;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;

    localparam int CPB   = 3;
    localparam int DEPTH = 4;
`ifdef UART_RX_FIFO_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif
    localparam int STOP_K = CPB / 2 + 9 * CPB + LAT;

    logic        clock = 1'b0;
    logic        tock_reset_n;
    logic        tock_serial;
    logic        tock_pop;
    logic        get_valid_ret;
    logic [7:0]  get_data_ret;
    logic [2:0]  get_count_ret;
    logic [31:0] get_checksum_ret;
    logic        get_frame_err_ret;
    logic        get_overflow_ret;
    logic        get_busy_ret;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]  m_q[$];
    logic [31:0] m_csum;
    bit          m_ferr;
    bit          m_ovf;

    typedef struct {
        bit          do_reset;
        bit          do_send;
        logic [7:0]  data;
        bit          stop;
        bit          do_pop;
        int          exp_count;
        logic [7:0]  exp_head;
        logic [31:0] exp_csum;
        bit          exp_fe;
        bit          exp_ov;
    } vec_t;

    vec_t tbl[10];

    always #5 clock = ~clock;

    uart_rx_fifo #(
        .cycles_per_bit (CPB),
        .fifo_depth     (DEPTH)
    ) dut (
        .clock             (clock),
        .tock_reset_n      (tock_reset_n),
        .tock_serial       (tock_serial),
        .tock_pop          (tock_pop),
        .get_valid_ret     (get_valid_ret),
        .get_data_ret      (get_data_ret),
        .get_count_ret     (get_count_ret),
        .get_checksum_ret  (get_checksum_ret),
        .get_frame_err_ret (get_frame_err_ret),
        .get_overflow_ret  (get_overflow_ret),
        .get_busy_ret      (get_busy_ret)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag, input int cnt, input logic [7:0] head,
                               input logic [31:0] cs, input bit fe, input bit ov);
        @(negedge clock);
        chk({tag, ".valid"}, 32'(get_valid_ret), 32'(cnt != 0));
        chk({tag, ".data"},  32'(get_data_ret), 32'(cnt != 0 ? head : 8'h00));
        chk({tag, ".count"}, 32'(get_count_ret), 32'(cnt));
        chk({tag, ".csum"},  get_checksum_ret, cs);
        chk({tag, ".ferr"},  32'(get_frame_err_ret), 32'(fe));
        chk({tag, ".ovf"},   32'(get_overflow_ret), 32'(ov));
        chk({tag, ".busy"},  32'(get_busy_ret), 32'd0);
    endtask

    task automatic check_model(input string tag);
        check_state(tag, m_q.size(), (m_q.size() != 0) ? m_q[0] : 8'h00, m_csum, m_ferr, m_ovf);
    endtask

    task automatic model_clear();
        m_q.delete();
        m_csum = '0;
        m_ferr = 1'b0;
        m_ovf  = 1'b0;
    endtask

    task automatic model_frame(input logic [7:0] d, input bit stop, input bit popped_same);
        if (stop) begin
            m_csum = m_csum + 32'(d);
            if (popped_same && m_q.size() != 0) begin
                void'(m_q.pop_front());
            end
            if (m_q.size() < DEPTH) begin
                m_q.push_back(d);
            end else begin
                m_ovf = 1'b1;
            end
        end else begin
            m_ferr = 1'b1;
        end
    endtask

    task automatic do_reset();
        @(posedge clock); #1;
        tock_reset_n = 1'b0;
        tock_serial  = 1'b1;
        tock_pop     = 1'b0;
        @(posedge clock); #1;
        tock_reset_n = 1'b1;
        model_clear();
    endtask

    task automatic pop_one();
        @(posedge clock); #1;
        tock_pop = 1'b1;
        @(posedge clock); #1;
        tock_pop = 1'b0;
        if (m_q.size() != 0) begin
            void'(m_q.pop_front());
        end
    endtask

    // Value driven at step k is first seen by the DUT input k edges after the start edge
    task automatic send_frame(input logic [7:0] d, input bit stop, input int drift_bit,
                              input int drift, input int pop_k, input int rst_k, input int gap);
        int   k;
        int   len;
        logic v;
        k = 0;
        for (int b = 0; b < 10; b++) begin
            v   = (b == 0) ? 1'b0 : (b == 9) ? stop : d[b-1];
            len = CPB + ((b == drift_bit) ? drift : 0);
            for (int c = 0; c < len; c++) begin
                @(posedge clock); #1;
                tock_serial  = v;
                tock_pop     = (k == pop_k);
                tock_reset_n = !(k == rst_k);
                if (k == 10 && (rst_k < 0 || rst_k > 10)) begin
                    chk("busy_mid_frame", 32'(get_busy_ret), 32'd1);
                end
                k++;
            end
        end
        for (int g = 0; g < gap; g++) begin
            @(posedge clock); #1;
            tock_serial  = 1'b1;
            tock_pop     = 1'b0;
            tock_reset_n = 1'b1;
        end
    endtask

    initial begin
        logic [7:0] d;
        bit         st;
        tbl[0] = '{1, 1, 8'h48, 1, 0, 1, 8'h48, 32'h48, 0, 0};
        tbl[1] = '{0, 0, 8'h00, 1, 1, 0, 8'h00, 32'h48, 0, 0};
        tbl[2] = '{1, 1, 8'h55, 0, 0, 0, 8'h00, 32'h00, 1, 0};
        tbl[3] = '{0, 1, 8'hA1, 1, 0, 1, 8'hA1, 32'hA1, 1, 0};
        tbl[4] = '{1, 1, 8'h01, 1, 0, 1, 8'h01, 32'h01, 0, 0};
        tbl[5] = '{0, 1, 8'h02, 1, 0, 2, 8'h01, 32'h03, 0, 0};
        tbl[6] = '{0, 1, 8'h03, 1, 0, 3, 8'h01, 32'h06, 0, 0};
        tbl[7] = '{0, 1, 8'h04, 1, 0, 4, 8'h01, 32'h0A, 0, 0};
        tbl[8] = '{0, 1, 8'h05, 1, 0, 4, 8'h01, 32'h0F, 0, 1};
        tbl[9] = '{0, 0, 8'h00, 1, 1, 3, 8'h02, 32'h0F, 0, 1};

        tock_reset_n = 1'b0;
        tock_serial  = 1'b1;
        tock_pop     = 1'b0;
        repeat (3) @(posedge clock);
        #1 tock_reset_n = 1'b1;
        model_clear();
        check_state("reset", 0, 8'h00, 32'h0, 0, 0);

        for (int i = 0; i < 10; i++) begin
            if (tbl[i].do_reset) do_reset();
            if (tbl[i].do_send) send_frame(tbl[i].data, tbl[i].stop, -1, 0, -1, -1, 2);
            if (tbl[i].do_pop) pop_one();
            check_state($sformatf("tbl%0d", i), tbl[i].exp_count, tbl[i].exp_head,
                        tbl[i].exp_csum, tbl[i].exp_fe, tbl[i].exp_ov);
        end

        // One-clock glitch on an idle line
        do_reset();
        @(posedge clock); #1 tock_serial = 1'b0;
        @(posedge clock); #1 tock_serial = 1'b1;
        repeat (6 + LAT) @(posedge clock);
        check_state("glitch", 0, 8'h00, 32'h0, 0, 0);

        // Push of the fifth byte coincides with a pop while full
        do_reset();
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1, -1, 0, -1, -1, 2);
        send_frame(8'h05, 1, -1, 0, STOP_K, -1, 2);
        check_state("full_push_pop", 4, 8'h02, 32'h0F, 0, 0);

        // Pop at the push edge while empty is ignored
        do_reset();
        send_frame(8'h77, 1, -1, 0, STOP_K, -1, 2);
        check_state("empty_push_pop", 1, 8'h77, 32'h77, 0, 0);

        // Reset in the middle of a 0xFF frame, then a clean 0x3C
        do_reset();
        send_frame(8'hFF, 1, -1, 0, -1, 13, 2);
        check_state("mid_reset", 0, 8'h00, 32'h0, 0, 0);
        send_frame(8'h3C, 1, -1, 0, -1, -1, 2);
        check_state("after_reset", 1, 8'h3C, 32'h3C, 0, 0);

        // Random traffic with drift, framing errors and pops against the queue model
        do_reset();
        for (int i = 0; i < 40; i++) begin
            d  = 8'($urandom);
            st = ($urandom_range(0, 7) != 0);
            send_frame(d, st, $urandom_range(0, 9), $urandom_range(0, 2) - 1, -1, -1,
                       $urandom_range(2, 4));
            model_frame(d, st, 1'b0);
            if ($urandom_range(0, 1) == 1 && m_q.size() != 0) pop_one();
            check_model($sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
